// File: rtl/udp_gmii_tx_param.sv
// GMII UDP/IPv4 frame transmitter: preamble, Ethernet/IP/UDP headers,
// fixed-size payload drained from a byte FIFO, zero pad to 64 bytes,
// internal CRC32 FCS and an enforced inter-frame gap.
module udp_gmii_tx_param #(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h000A_3501_FEC0,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_0002,
  parameter logic [31:0] DST_IP      = 32'hC0A8_0003,
  parameter logic [15:0] SRC_PORT    = 16'h1F90,
  parameter logic [15:0] DST_PORT    = 16'h1F90,
  parameter int unsigned PAYLOAD_LEN = 1024,
  parameter int unsigned CNT_W       = 11,
  parameter int unsigned IFG_CYCLES  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_enable,
  input  logic [7:0]       fifo_data,
  input  logic [CNT_W-1:0] fifo_count,
  output logic             fifo_rd_en,
  output logic             gmii_tx_en,
  output logic             gmii_tx_er,
  output logic [7:0]       gmii_txd,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [15:0]      TOTAL_LEN = 16'(28 + PAYLOAD_LEN);
  localparam logic [15:0]      UDP_LEN   = 16'(8 + PAYLOAD_LEN);
  localparam logic [CNT_W-1:0] START_TH  = CNT_W'(PAYLOAD_LEN);
  localparam logic [10:0]      PAY_LAST  = 11'(PAYLOAD_LEN - 1);
  localparam logic [10:0]      PAD_LAST  = (PAYLOAD_LEN < 18) ? 11'(17 - PAYLOAD_LEN) : 11'd0;
  localparam logic [10:0]      IFG_LAST  = 11'(IFG_CYCLES - 2);
  localparam logic [31:0]      CSUM_BASE = 32'h4500 + 32'(TOTAL_LEN) + 32'h4000 + 32'h8011
                                         + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0])
                                         + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CALC = 4'd1,
    S_PRE  = 4'd2,
    S_HDR  = 4'd3,
    S_PAY  = 4'd4,
    S_PAD  = 4'd5,
    S_FCS  = 4'd6,
    S_IFG  = 4'd7
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [15:0] ip_id_q, ip_id_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] csum_q, csum_d;
  logic [31:0] crc_q, crc_d;

  logic [335:0] hdr;
  logic [5:0]   hdr_idx;
  logic [31:0]  fcs;

  // Reflected CRC32 (Ethernet), one byte, LSB first
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ip_id_q <= '0;
      acc_q   <= '0;
      csum_q  <= '0;
      crc_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ip_id_q <= ip_id_d;
      acc_q   <= acc_d;
      csum_q  <= csum_d;
      crc_q   <= crc_d;
    end
  end

  // Next-state, byte mux, CRC/checksum update and output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ip_id_d    = ip_id_q;
    acc_d      = acc_q;
    csum_d     = csum_q;
    crc_d      = crc_q;
    fifo_rd_en = 1'b0;
    gmii_tx_en = 1'b0;
    gmii_tx_er = 1'b0;
    gmii_txd   = 8'h00;
    frame_done = 1'b0;
    busy       = (state_q != S_IDLE);
    hdr        = {DST_MAC, SRC_MAC, 16'h0800,
                  16'h4500, TOTAL_LEN, ip_id_q, 16'h4000, 16'h8011, csum_q, SRC_IP, DST_IP,
                  SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};
    hdr_idx    = 6'd41 - cnt_q[5:0];
    fcs        = ~crc_q;

    case (state_q)
      S_IDLE: begin
        crc_d = '1;
        cnt_d = '0;
        if (tx_enable && (fifo_count >= START_TH)) state_d = S_CALC;
      end
      S_CALC: begin
        cnt_d = cnt_q + 11'd1;
        case (cnt_q[1:0])
          2'd0:    acc_d = CSUM_BASE + {16'h0, ip_id_q};
          2'd1:    acc_d = {16'h0, acc_q[15:0]} + {16'h0, acc_q[31:16]};
          default: begin
            csum_d  = ~(acc_q[15:0] + acc_q[31:16]);
            cnt_d   = '0;
            state_d = S_PRE;
          end
        endcase
      end
      S_PRE: begin
        gmii_tx_en = 1'b1;
        gmii_txd   = (cnt_q == 11'd7) ? 8'hD5 : 8'h55;
        cnt_d      = cnt_q + 11'd1;
        if (cnt_q == 11'd7) begin
          cnt_d   = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        gmii_tx_en = 1'b1;
        gmii_txd   = hdr[{hdr_idx, 3'b000} +: 8];
        crc_d      = crc_upd(crc_q, gmii_txd);
        fifo_rd_en = (cnt_q == 11'd41);
        cnt_d      = cnt_q + 11'd1;
        if (cnt_q == 11'd41) begin
          cnt_d   = '0;
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        gmii_tx_en = 1'b1;
        gmii_txd   = fifo_data;
        crc_d      = crc_upd(crc_q, fifo_data);
        fifo_rd_en = (cnt_q < PAY_LAST);
        cnt_d      = cnt_q + 11'd1;
        if (cnt_q == PAY_LAST) begin
          cnt_d   = '0;
          state_d = (PAYLOAD_LEN < 18) ? S_PAD : S_FCS;
        end
      end
      S_PAD: begin
        gmii_tx_en = 1'b1;
        crc_d      = crc_upd(crc_q, 8'h00);
        cnt_d      = cnt_q + 11'd1;
        if (cnt_q == PAD_LAST) begin
          cnt_d   = '0;
          state_d = S_FCS;
        end
      end
      S_FCS: begin
        gmii_tx_en = 1'b1;
        gmii_txd   = fcs[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d      = cnt_q + 11'd1;
        if (cnt_q == 11'd3) begin
          frame_done = 1'b1;
          cnt_d      = '0;
          state_d    = S_IFG;
        end
      end
      S_IFG: begin
        // IFG holds IFG_CYCLES-1 cycles; the IDLE cycle that follows completes the gap
        if (cnt_q == 11'd0) ip_id_d = ip_id_q + 16'd1;
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == IFG_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        gmii_tx_er = 1'b1;
        cnt_d      = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_udp_gmii_tx_param.sv
// Bench for udp_gmii_tx_param: random FIFO payloads, frames captured from GMII
// and compared against a frame builder working from the field layout.
module tb_udp_gmii_tx_param;

  typedef logic [7:0] bq_t[$];
  localparam int LEN_A = 1024;
  localparam int LEN_B = 8;

  logic clk;
  logic rst_n;
  logic ten_a, ten_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: bench advances wp, FIFO process advances rp
  logic [7:0] mem_a [0:16383];
  logic [7:0] mem_b [0:16383];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
  logic [7:0]  fd_a = 8'h00, fd_b = 8'h00;
  logic [10:0] fc_a, fc_b;
  logic        rd_a, txen_a, txer_a, busy_a, done_a;
  logic        rd_b, txen_b, txer_b, busy_b, done_b;
  logic [7:0]  txd_a, txd_b;

  assign fc_a = (wp_a - rp_a > 2047) ? 11'd2047 : 11'(wp_a - rp_a);
  assign fc_b = (wp_b - rp_b > 2047) ? 11'd2047 : 11'(wp_b - rp_b);

  always @(posedge clk) begin
    if (rd_a) begin fd_a <= mem_a[rp_a & 16383]; rp_a <= rp_a + 1; end
    if (rd_b) begin fd_b <= mem_b[rp_b & 16383]; rp_b <= rp_b + 1; end
  end

  udp_gmii_tx_param dut_a (
    .clk(clk), .rst_n(rst_n), .tx_enable(ten_a), .fifo_data(fd_a), .fifo_count(fc_a),
    .fifo_rd_en(rd_a), .gmii_tx_en(txen_a), .gmii_tx_er(txer_a), .gmii_txd(txd_a),
    .busy(busy_a), .frame_done(done_a));

  udp_gmii_tx_param #(.PAYLOAD_LEN(LEN_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_enable(ten_b), .fifo_data(fd_b), .fifo_count(fc_b),
    .fifo_rd_en(rd_b), .gmii_tx_en(txen_b), .gmii_tx_er(txer_b), .gmii_txd(txd_b),
    .busy(busy_b), .frame_done(done_b));

  // Capture: bytes while tx_en, per-frame length, start rp, reads, frame_done position
  bq_t cap_a, cap_b;
  int flen_a[$], frp_a[$], frd_a[$], fdp_a[$], gap_a[$];
  int flen_b[$], frp_b[$], frd_b[$], fdp_b[$];
  int cl_a = 0, cr_a = 0, cf_a = -1, low_a = 0;
  int cl_b = 0, cr_b = 0, cf_b = -1;
  bit seen_a = 1'b0;
  int er_cnt = 0, stray_done = 0;

  always @(negedge clk) begin
    if (txer_a || txer_b) er_cnt++;
    if (txen_a) begin
      if (cl_a == 0) begin
        frp_a.push_back(rp_a);
        if (seen_a) gap_a.push_back(low_a);
        seen_a = 1'b1;
      end
      low_a = 0;
      cap_a.push_back(txd_a);
      cl_a++;
      if (rd_a) cr_a++;
      if (done_a) cf_a = cl_a;
    end else begin
      low_a++;
      if (done_a) stray_done++;
      if (cl_a != 0) begin
        flen_a.push_back(cl_a); frd_a.push_back(cr_a); fdp_a.push_back(cf_a);
        cl_a = 0; cr_a = 0; cf_a = -1;
      end
    end
    if (txen_b) begin
      if (cl_b == 0) frp_b.push_back(rp_b);
      cap_b.push_back(txd_b);
      cl_b++;
      if (rd_b) cr_b++;
      if (done_b) cf_b = cl_b;
    end else begin
      if (done_b) stray_done++;
      if (cl_b != 0) begin
        flen_b.push_back(cl_b); frd_b.push_back(cr_b); fdp_b.push_back(cf_b);
        cl_b = 0; cr_b = 0; cf_b = -1;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ip_cks(input int plen, input logic [15:0] id);
    logic [31:0] s;
    logic [15:0] w [10];
    w = '{16'h4500, 16'(28 + plen), id, 16'h4000, 16'h8011, 16'h0000,
          16'hC0A8, 16'h0002, 16'hC0A8, 16'h0003};
    s = 32'h0;
    foreach (w[i]) s += 32'(w[i]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  function automatic void build_frame(input int plen, input logic [15:0] id, input int rp,
                                      input bit is_b, output bq_t fr);
    bq_t body;
    logic [15:0] hw [21];
    logic [31:0] crc;
    hw = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h000A, 16'h3501, 16'hFEC0, 16'h0800,
           16'h4500, 16'(28 + plen), id, 16'h4000, 16'h8011, ip_cks(plen, id),
           16'hC0A8, 16'h0002, 16'hC0A8, 16'h0003,
           16'h1F90, 16'h1F90, 16'(8 + plen), 16'h0000};
    body = {};
    foreach (hw[i]) begin body.push_back(hw[i][15:8]); body.push_back(hw[i][7:0]); end
    for (int i = 0; i < plen; i++)
      body.push_back(is_b ? mem_b[(rp + i) & 16383] : mem_a[(rp + i) & 16383]);
    while (body.size() < 60) body.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    foreach (body[i]) begin
      crc ^= {24'h0, body[i]};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    crc = ~crc;
    fr = {};
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    foreach (body[i]) fr.push_back(body[i]);
    for (int i = 0; i < 4; i++) fr.push_back(crc[8*i +: 8]);
  endfunction

  task automatic wait_frames(input bit is_b, input int n, input int budget, input string tag);
    int c;
    c = 0;
    while ((is_b ? flen_b.size() : flen_a.size()) < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk({tag, "_timeout"}, 64'(c < budget), 64'd1);
  endtask

  task automatic wait_txen_a(input int budget, input string tag, output int n);
    n = 0;
    while (!txen_a && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_start"}, 64'(txen_a), 64'd1);
  endtask

  task automatic check_frame(input string tag, input bit is_b, input logic [15:0] id,
                             output logic [15:0] cks_got, output logic [15:0] tl_got,
                             output logic [15:0] ul_got);
    bq_t exp;
    int len, rp, fdp, rdn, plen, bad;
    logic [7:0] g;
    cks_got = '0; tl_got = '0; ul_got = '0;
    plen = is_b ? LEN_B : LEN_A;
    wait_frames(is_b, 1, 5000, tag);
    if ((is_b ? flen_b.size() : flen_a.size()) == 0) return;
    if (is_b) begin
      len = flen_b.pop_front(); rp = frp_b.pop_front(); fdp = fdp_b.pop_front(); rdn = frd_b.pop_front();
    end else begin
      len = flen_a.pop_front(); rp = frp_a.pop_front(); fdp = fdp_a.pop_front(); rdn = frd_a.pop_front();
    end
    build_frame(plen, id, rp, is_b, exp);
    chk({tag, "_len"}, 64'(len), 64'(exp.size()));
    bad = 0;
    for (int i = 0; i < len; i++) begin
      g = is_b ? cap_b.pop_front() : cap_a.pop_front();
      if (i == 24) tl_got[15:8] = g;
      if (i == 25) tl_got[7:0] = g;
      if (i == 32) cks_got[15:8] = g;
      if (i == 33) cks_got[7:0] = g;
      if (i == 46) ul_got[15:8] = g;
      if (i == 47) ul_got[7:0] = g;
      if (i >= exp.size() || g !== exp[i]) bad++;
    end
    chk({tag, "_bad_bytes"}, 64'(bad), 64'd0);
    chk({tag, "_done_pos"}, 64'(fdp), 64'(exp.size()));
    chk({tag, "_rd_cnt"}, 64'(rdn), 64'(plen));
    chk({tag, "_ip_cks"}, 64'(cks_got), 64'(ip_cks(plen, id)));
  endtask

  initial begin
    logic [15:0] c0, c1, c2, tl, ul;
    int n, len, junk;
    rst_n = 1'b0; ten_a = 1'b0; ten_b = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
    #2;
    chk("reset_outs_a", {txen_a, rd_a, busy_a, done_a, txer_a, txd_a}, 64'd0);
    chk("reset_outs_b", {txen_b, rd_b, busy_b, done_b, txer_b, txd_b}, 64'd0);
    #20 rst_n = 1'b1;

    // Start threshold: 1023 bytes never starts a frame
    ten_a = 1'b1;
    wp_a  = LEN_A - 1;
    repeat (40) @(posedge clk);
    #1;
    chk("t2_idle_busy", 64'(busy_a), 64'd0);
    chk("t2_idle_txen", 64'(txen_a), 64'd0);
    wp_a = LEN_A;
    wait_txen_a(20, "t2", n);
    chk("t2_latency", 64'(n), 64'd4);

    // Three frames back to back, ids 0,1,2
    wp_a = 4 * LEN_A;
    check_frame("t1_f0", 1'b0, 16'd0, c0, tl, ul);
    chk("t1_total_len", 64'(tl), 64'h041C);
    chk("t1_udp_len", 64'(ul), 64'h0408);
    check_frame("t4_f1", 1'b0, 16'd1, c1, tl, ul);
    chk("t4_cks_step", 64'(16'(c0 - c1)), 64'd1);

    // tx_enable dropped part way through the third frame
    wait_txen_a(100, "t6", n);
    repeat (200) @(posedge clk);
    ten_a = 1'b0;
    check_frame("t6_f2", 1'b0, 16'd2, c2, tl, ul);
    chk("t4_cks_step2", 64'(16'(c1 - c2)), 64'd1);
    chk("t4_gap_cnt", 64'(gap_a.size()), 64'd2);
    if (gap_a.size() >= 2) begin
      chk("t4_gap1", 64'(gap_a.pop_front()), 64'd15);
      chk("t4_gap2", 64'(gap_a.pop_front()), 64'd15);
    end
    repeat (300) @(posedge clk);
    #1;
    chk("t6_no_frame_busy", 64'(busy_a), 64'd0);
    chk("t6_no_frame_cnt", 64'(flen_a.size() + cl_a), 64'd0);

    // Reset during payload byte 100 of frame id 3
    ten_a = 1'b1;
    wait_txen_a(20, "t5", n);
    repeat (150) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_drop", {txen_a, rd_a, busy_a}, 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_frames(1'b0, 1, 10, "t5_trunc");
    if (flen_a.size() > 0) begin
      len = flen_a.pop_front();
      junk = frp_a.pop_front();
      chk("t5_trunc_rd", 64'(frd_a.pop_front()), 64'd101);
      chk("t5_trunc_done", 64'(fdp_a.pop_front()), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t5_trunc_len", 64'(len), 64'd150);
      for (int i = 0; i < len; i++) junk = int'(cap_a.pop_front());
    end
    wp_a = wp_a + LEN_A;
    check_frame("t5_after", 1'b0, 16'd0, c0, tl, ul);
    ten_a = 1'b0;

    // Short payload: padded to 64 bytes
    ten_b = 1'b1;
    wp_b  = LEN_B;
    check_frame("t3_f0", 1'b1, 16'd0, c0, tl, ul);
    chk("t3_total_len", 64'(tl), 64'h0024);
    wp_b = 2 * LEN_B;
    check_frame("t3_f1", 1'b1, 16'd1, c1, tl, ul);
    chk("t3_cks_step", 64'(16'(c0 - c1)), 64'd1);

    chk("tx_er_never", 64'(er_cnt), 64'd0);
    chk("stray_done", 64'(stray_done), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
